// File: rtl/tile_mm_sequencer_if.sv
// ----------------------------------------------------------------------------
// tile_mm_sequencer_if
// Handshake and bus bundle between the tile matrix-multiply sequencer and the
// shared matrix RAM / vector unit it drives.
//
//   start       run request into the sequencer
//   load_a      RAM A-vector read strobe
//   load_w      RAM W-vector read strobe
//   deload_out  RAM result-write strobe
//   addr_a      A read address
//   addr_w      W read address
//   addr_res    result write address
//   mac_en      vector unit accumulate enable (RAM read latency aligned)
//   acc_clr     vector unit load-instead-of-accumulate (first step of a tile)
//   test_en     RAM result dump enable
//   busy        run in progress
//   done        one-cycle completion pulse
//
// master: the sequencer side.  slave: the controlling / observing side.
// ----------------------------------------------------------------------------
interface tile_mm_sequencer_if #(
   parameter int ADDR_WIDTH = 10
) ();

   logic                  start;
   logic                  load_a;
   logic                  load_w;
   logic                  deload_out;
   logic [ADDR_WIDTH-1:0] addr_a;
   logic [ADDR_WIDTH-1:0] addr_w;
   logic [ADDR_WIDTH-1:0] addr_res;
   logic                  mac_en;
   logic                  acc_clr;
   logic                  test_en;
   logic                  busy;
   logic                  done;

   modport master (
      input  start,
      output load_a, load_w, deload_out,
      output addr_a, addr_w, addr_res,
      output mac_en, acc_clr, test_en,
      output busy, done
   );

   modport slave (
      output start,
      input  load_a, load_w, deload_out,
      input  addr_a, addr_w, addr_res,
      input  mac_en, acc_clr, test_en,
      input  busy, done
   );

endinterface

// File: rtl/tile_mm_sequencer.sv
// ----------------------------------------------------------------------------
// tile_mm_sequencer
// Initiator for the shared matrix RAM.  One accepted start runs NUM_TILES
// output tiles (COL_M A/W vector reads, a drain, a two-cycle result store per
// tile), then streams NUM_TILES*ROW_A result words with test_en, then pulses
// done.  mac_en / acc_clr are the read strobe delayed by the RAM read latency.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts a run, clears all outputs
//   bus    tile_mm_sequencer_if.master (start in; strobes, addresses,
//          vector-unit control, busy, done out)
// ----------------------------------------------------------------------------
module tile_mm_sequencer #(
   parameter int ADDR_WIDTH    = 10,
   parameter int ROW_A         = 16,
   parameter int COL_M         = 16,
   parameter int NUM_TILES     = 16,
   parameter int A_BASE        = 0,
   parameter int W_BASE        = 256,
   parameter int C_BASE        = 512,
   parameter int W_TILE_STRIDE = 16,
   parameter int W_STEP_STRIDE = 1,
   parameter int RD_LAT        = 2,
   parameter int PE_LAT        = 1
) (
   input logic                 clk,
   input logic                 rst_n,
   tile_mm_sequencer_if.master bus
);

   typedef logic [ADDR_WIDTH-1:0] addr_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DRAIN,
      S_STORE0,
      S_STORE1,
      S_DUMP,
      S_DONE
   } state_t;

   localparam int DRAIN_LEN = RD_LAT + PE_LAT;
   localparam int DUMP_LEN  = NUM_TILES * ROW_A;
   localparam int TMR_MAX   = (DUMP_LEN > DRAIN_LEN) ? DUMP_LEN : DRAIN_LEN;

   localparam int K_W   = (COL_M > 1)     ? $clog2(COL_M)     : 1;
   localparam int T_W   = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
   localparam int TMR_W = (TMR_MAX > 1)   ? $clog2(TMR_MAX)   : 1;

   localparam logic [K_W-1:0]   K_LAST     = K_W'(COL_M - 1);
   localparam logic [T_W-1:0]   T_LAST     = T_W'(NUM_TILES - 1);
   localparam logic [TMR_W-1:0] DRAIN_LAST = TMR_W'(DRAIN_LEN - 1);
   localparam logic [TMR_W-1:0] DUMP_LAST  = TMR_W'(DUMP_LEN - 1);

   state_t           state_q, state_d;
   logic [K_W-1:0]   k_q, k_d;        // reduction step within the tile
   logic [T_W-1:0]   t_q, t_d;        // output tile index
   logic [TMR_W-1:0] tmr_q, tmr_d;    // DRAIN / DUMP cycle counter

   logic  load, deload, test_en, busy, done;
   addr_t addr_a, addr_w, addr_res, res_addr;

   // Read-latency delay lines for the vector-unit controls.
   logic [RD_LAT-1:0] mac_pipe_q;
   logic [RD_LAT-1:0] clr_pipe_q;

   // All address arithmetic is done in int and truncated, so it wraps
   // modulo 2^ADDR_WIDTH.
   assign res_addr = addr_t'(C_BASE + int'(t_q) * ROW_A);

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every register samples the pre-edge value of every other register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         t_q     <= '0;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         t_q     <= t_d;
         tmr_q   <= tmr_d;
      end
   end

   // NOTE: every signal driven here gets a default first; a path that leaves
   // one unassigned would infer a latch.
   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      t_d      = t_q;
      tmr_d    = tmr_q;
      load     = 1'b0;
      deload   = 1'b0;
      test_en  = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      addr_a   = '0;
      addr_w   = '0;
      addr_res = '0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_LOAD;
               k_d     = '0;
               t_d     = '0;
            end
         end
         S_LOAD: begin
            busy   = 1'b1;
            load   = 1'b1;
            addr_a = addr_t'(A_BASE + int'(k_q));
            addr_w = addr_t'(W_BASE + int'(t_q) * W_TILE_STRIDE
                             + int'(k_q) * W_STEP_STRIDE);
            if (k_q == K_LAST) begin
               k_d     = '0;
               tmr_d   = '0;
               state_d = S_DRAIN;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         S_DRAIN: begin
            // Covers the last read's latency plus accumulator settle.
            busy = 1'b1;
            if (tmr_q == DRAIN_LAST) begin
               state_d = S_STORE0;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         S_STORE0: begin
            busy     = 1'b1;
            deload   = 1'b1;
            addr_res = res_addr;
            state_d  = S_STORE1;
         end
         S_STORE1: begin
            // The RAM registers deload_out, so addr_res stays valid one more cycle.
            busy     = 1'b1;
            addr_res = res_addr;
            if (t_q == T_LAST) begin
               t_d     = '0;
               tmr_d   = '0;
               state_d = S_DUMP;
            end else begin
               t_d     = t_q + 1'b1;
               state_d = S_LOAD;
            end
         end
         S_DUMP: begin
            busy    = 1'b1;
            test_en = 1'b1;
            if (tmr_q == DUMP_LAST) begin
               state_d = S_DONE;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         S_DONE: begin
            // start is not looked at here, so a request in the done cycle is dropped.
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: the delay lines are reset so an aborted run cannot leave a stale
   // mac_en / acc_clr in flight toward the vector unit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mac_pipe_q <= '0;
         clr_pipe_q <= '0;
      end else begin
         mac_pipe_q[0] <= load;
         clr_pipe_q[0] <= load && (k_q == '0);
         for (int i = 1; i < RD_LAT; i++) begin
            mac_pipe_q[i] <= mac_pipe_q[i-1];
            clr_pipe_q[i] <= clr_pipe_q[i-1];
         end
      end
   end

   assign bus.load_a     = load;
   assign bus.load_w     = load;
   assign bus.deload_out = deload;
   assign bus.addr_a     = addr_a;
   assign bus.addr_w     = addr_w;
   assign bus.addr_res   = addr_res;
   assign bus.mac_en     = mac_pipe_q[RD_LAT-1];
   assign bus.acc_clr    = clr_pipe_q[RD_LAT-1];
   assign bus.test_en    = test_en;
   assign bus.busy       = busy;
   assign bus.done       = done;

endmodule

// File: tb/tb_tile_mm_sequencer.sv
// ----------------------------------------------------------------------------
// tb_tile_mm_sequencer
// Drives three sequencer instances (small 4x4x2 config, 4-bit wrapping
// address config, default config) and compares every output, every cycle,
// against a reference computed from cycle index arithmetic.
// ----------------------------------------------------------------------------
module tb_tile_mm_sequencer;

   typedef struct packed {
      logic       load_a;
      logic       load_w;
      logic       deload_out;
      logic       mac_en;
      logic       acc_clr;
      logic       test_en;
      logic       busy;
      logic       done;
      logic [9:0] addr_a;
      logic [9:0] addr_w;
      logic [9:0] addr_res;
   } obs_t;

   typedef struct {
      int aw;
      int row_a;
      int col_m;
      int nt;
      int a_base;
      int w_base;
      int c_base;
      int wts;
      int wss;
      int rd;
      int pe;
   } cfg_t;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   tile_mm_sequencer_if #(.ADDR_WIDTH(10)) bus_s ();
   tile_mm_sequencer_if #(.ADDR_WIDTH(4))  bus_w ();
   tile_mm_sequencer_if #(.ADDR_WIDTH(10)) bus_d ();

   tile_mm_sequencer #(.ROW_A(4), .COL_M(4), .NUM_TILES(2)) dut_s (
      .clk(clk), .rst_n(rst_n), .bus(bus_s.master));

   tile_mm_sequencer #(.ADDR_WIDTH(4), .A_BASE(14), .ROW_A(4), .COL_M(4),
                       .NUM_TILES(2)) dut_w (
      .clk(clk), .rst_n(rst_n), .bus(bus_w.master));

   tile_mm_sequencer dut_d (
      .clk(clk), .rst_n(rst_n), .bus(bus_d.master));

   function automatic cfg_t get_cfg(input int which);
      cfg_t c;
      c = '{aw: 10, row_a: 16, col_m: 16, nt: 16, a_base: 0, w_base: 256,
            c_base: 512, wts: 16, wss: 1, rd: 2, pe: 1};
      if (which == 0) begin
         c.row_a = 4; c.col_m = 4; c.nt = 2;
      end else if (which == 1) begin
         c.aw = 4; c.a_base = 14; c.row_a = 4; c.col_m = 4; c.nt = 2;
      end
      return c;
   endfunction

   function automatic obs_t get_obs(input int which);
      obs_t o;
      if (which == 0) begin
         o = '{bus_s.load_a, bus_s.load_w, bus_s.deload_out, bus_s.mac_en,
               bus_s.acc_clr, bus_s.test_en, bus_s.busy, bus_s.done,
               bus_s.addr_a, bus_s.addr_w, bus_s.addr_res};
      end else if (which == 1) begin
         o = '{bus_w.load_a, bus_w.load_w, bus_w.deload_out, bus_w.mac_en,
               bus_w.acc_clr, bus_w.test_en, bus_w.busy, bus_w.done,
               10'(bus_w.addr_a), 10'(bus_w.addr_w), 10'(bus_w.addr_res)};
      end else begin
         o = '{bus_d.load_a, bus_d.load_w, bus_d.deload_out, bus_d.mac_en,
               bus_d.acc_clr, bus_d.test_en, bus_d.busy, bus_d.done,
               bus_d.addr_a, bus_d.addr_w, bus_d.addr_res};
      end
      return o;
   endfunction

   task automatic set_start(input int which, input logic v);
      if (which == 0)      bus_s.start = v;
      else if (which == 1) bus_w.start = v;
      else                 bus_d.start = v;
   endtask

   // Expected outputs at cycle cyc of a run; cycle 0 is the cycle start is
   // raised.  Tile t owns cycles [1+t*per, 1+(t+1)*per).
   function automatic obs_t model(input cfg_t c, input int cyc);
      obs_t e;
      int   per, tiles_end, done_c, mask, t, o, lc;
      e         = '0;
      per       = c.col_m + c.rd + c.pe + 2;
      tiles_end = 1 + c.nt * per;
      done_c    = tiles_end + c.nt * c.row_a;
      mask      = (1 << c.aw) - 1;
      if (cyc >= 1 && cyc < done_c) e.busy = 1'b1;
      if (cyc == done_c) e.done = 1'b1;
      if (cyc >= 1 && cyc < tiles_end) begin
         t = (cyc - 1) / per;
         o = (cyc - 1) % per;
         if (o < c.col_m) begin
            e.load_a = 1'b1;
            e.load_w = 1'b1;
            e.addr_a = 10'((c.a_base + o) & mask);
            e.addr_w = 10'((c.w_base + t * c.wts + o * c.wss) & mask);
         end
         if (o == c.col_m + c.rd + c.pe) e.deload_out = 1'b1;
         if (o >= c.col_m + c.rd + c.pe)
            e.addr_res = 10'((c.c_base + t * c.row_a) & mask);
      end
      if (cyc >= tiles_end && cyc < done_c) e.test_en = 1'b1;
      lc = cyc - c.rd;
      if (lc >= 1 && lc < tiles_end) begin
         o = (lc - 1) % per;
         if (o < c.col_m) e.mac_en = 1'b1;
         if (o == 0) e.acc_clr = 1'b1;
      end
      return e;
   endfunction

   // Entered and left just after a rising edge.  mode: 0 start only in cycle
   // 0, 1 random start while busy, 2 start held through done, 3 random start
   // pulses during the dump only.
   task automatic run_seq(input int which, input int gap, input int mode,
                          input int tail, input string name);
      cfg_t c;
      obs_t o, e, z;
      logic s;
      int   per, dump_lo, done_c;
      int   n_load, n_mac, n_clr, n_test, n_done, n_dl;
      c       = get_cfg(which);
      per     = c.col_m + c.rd + c.pe + 2;
      dump_lo = 1 + c.nt * per;
      done_c  = dump_lo + c.nt * c.row_a;
      z       = '0;
      for (int g = 0; g < gap; g++) begin
         set_start(which, 1'b0);
         @(negedge clk);
         o = get_obs(which);
         total++;
         if (o !== z) begin
            bad++;
            $display("FAIL %s idle dut=%0d got=%p want=%p", name, which, o, z);
         end
         @(posedge clk); #1;
      end
      n_load = 0; n_mac = 0; n_clr = 0; n_test = 0; n_done = 0; n_dl = 0;
      for (int cyc = 0; cyc <= done_c + tail; cyc++) begin
         if (cyc == 0)          s = 1'b1;
         else if (cyc > done_c) s = 1'b0;
         else begin
            case (mode)
               1:       s = 1'($urandom_range(0, 1));
               2:       s = 1'b1;
               3:       s = (cyc == dump_lo) ||
                            (cyc > dump_lo && cyc < done_c && $urandom_range(0, 1) == 1);
               default: s = 1'b0;
            endcase
         end
         set_start(which, s);
         @(negedge clk);
         o = get_obs(which);
         e = model(c, cyc);
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL %s dut=%0d cyc=%0d got=%p want=%p", name, which, cyc, o, e);
         end
         n_load += int'(o.load_a);
         n_mac  += int'(o.mac_en);
         n_clr  += int'(o.acc_clr);
         n_test += int'(o.test_en);
         n_done += int'(o.done);
         n_dl   += int'(o.deload_out);
         @(posedge clk); #1;
      end
      set_start(which, 1'b0);
      total++;
      if (n_load !== c.nt * c.col_m) begin
         bad++; $display("FAIL %s load_count got=%0d want=%0d", name, n_load, c.nt * c.col_m);
      end
      total++;
      if (n_mac !== c.nt * c.col_m) begin
         bad++; $display("FAIL %s mac_count got=%0d want=%0d", name, n_mac, c.nt * c.col_m);
      end
      total++;
      if (n_clr !== c.nt) begin
         bad++; $display("FAIL %s clr_count got=%0d want=%0d", name, n_clr, c.nt);
      end
      total++;
      if (n_test !== c.nt * c.row_a) begin
         bad++; $display("FAIL %s test_en_count got=%0d want=%0d", name, n_test, c.nt * c.row_a);
      end
      total++;
      if (n_done !== 1) begin
         bad++; $display("FAIL %s done_count got=%0d want=1", name, n_done);
      end
      total++;
      if (n_dl !== c.nt) begin
         bad++; $display("FAIL %s deload_count got=%0d want=%0d", name, n_dl, c.nt);
      end
   endtask

   task automatic test_reset();
      obs_t o, z;
      z     = '0;
      rst_n = 1'b0;
      bus_s.start = 1'b0;
      bus_w.start = 1'b0;
      bus_d.start = 1'b0;
      #1;
      for (int w = 0; w < 3; w++) begin
         o = get_obs(w);
         total++;
         if (o !== z) begin
            bad++;
            $display("FAIL reset dut=%0d got=%p want=%p", w, o, z);
         end
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_small_directed();
      run_seq(0, 0, 0, 2, "small");
   endtask

   task automatic test_random_runs();
      for (int i = 0; i < 4; i++)
         run_seq(i % 2, int'($urandom_range(0, 4)), 1, 1, "random");
   endtask

   task automatic test_start_held();
      run_seq(0, 1, 2, 3, "start_held");
   endtask

   task automatic test_start_in_dump();
      run_seq(0, 0, 3, 3, "start_in_dump");
   endtask

   task automatic test_back_to_back();
      run_seq(0, 0, 2, 0, "b2b_first");
      run_seq(0, 0, 0, 2, "b2b_second");
   endtask

   task automatic test_reset_mid_run();
      cfg_t c;
      obs_t o, e, z;
      int   per, target;
      c      = get_cfg(0);
      per    = c.col_m + c.rd + c.pe + 2;
      target = 1 + per + 1;    // second LOAD cycle of tile 1
      z      = '0;
      for (int cyc = 0; cyc <= target; cyc++) begin
         set_start(0, cyc == 0);
         @(negedge clk);
         o = get_obs(0);
         e = model(c, cyc);
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL mid_reset_pre cyc=%0d got=%p want=%p", cyc, o, e);
         end
         if (cyc < target) begin
            @(posedge clk); #1;
         end
      end
      #2 rst_n = 1'b0;
      #1;
      o = get_obs(0);
      total++;
      if (o !== z) begin
         bad++;
         $display("FAIL mid_reset_async got=%p want=%p", o, z);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         o = get_obs(0);
         total++;
         if (o !== z) begin
            bad++;
            $display("FAIL mid_reset_hold i=%0d got=%p want=%p", i, o, z);
         end
      end
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      run_seq(0, 1, 0, 2, "rerun_after_reset");
   endtask

   task automatic test_addr_wrap();
      run_seq(1, 0, 0, 1, "addr_wrap");
   endtask

   task automatic test_defaults();
      run_seq(2, 1, 1, 1, "defaults");
   endtask

   initial begin
      test_reset();
      test_small_directed();
      test_random_runs();
      test_start_held();
      test_start_in_dump();
      test_back_to_back();
      test_reset_mid_run();
      test_addr_wrap();
      test_defaults();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/tile_mm_sequencer.md
Name: tile_mm_sequencer

Overview:
- Initiator for the shared matrix RAM. Drives load_a/load_w/deload_out, addr_a/addr_w/addr_res and test_en.
- Also drives the vector-unit control (mac_en, acc_clr), aligned to the RAM's 2-cycle read latency.
- One start runs NUM_TILES output tiles of ROW_A words each, then a result dump, then pulses done.

Parameters:
ADDR_WIDTH, 10, RAM address width; all address arithmetic is mod 2^ADDR_WIDTH
ROW_A, 16, lanes per vector (words written per tile)
COL_M, 16, reduction steps per tile
NUM_TILES, 16, output tiles per run
A_BASE, 0, base address of A
W_BASE, 256, base address of W
C_BASE, 512, base address of results
W_TILE_STRIDE, 16, addr_w increment per tile
W_STEP_STRIDE, 1, addr_w increment per step
RD_LAT, 2, cycles from load_* to RAM data valid
PE_LAT, 1, cycles from last mac_en to accumulator output stable

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle run request; ignored while busy
load_a  out  1  RAM A-vector read strobe
load_w  out  1  RAM W-vector read strobe
deload_out  out  1  RAM result-write strobe
addr_a  out  ADDR_WIDTH  A read address
addr_w  out  ADDR_WIDTH  W read address
addr_res  out  ADDR_WIDTH  result write address
mac_en  out  1  vector unit: accumulate current a/w
acc_clr  out  1  vector unit: load instead of accumulate (first step of a tile)
test_en  out  1  RAM result dump enable
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_n=0): every output 0, including all addresses; counters t=0, k=0; state IDLE. Reset mid-run aborts immediately: no done pulse, no further strobes. Pending mac_en/acc_clr pipeline is cleared.
- States: IDLE -> LOAD -> DRAIN -> STORE0 -> STORE1 -> (LOAD if t<NUM_TILES-1, else DUMP) -> IDLE.
- IDLE: start=1 -> LOAD, busy=1, t=0, k=0. Otherwise outputs are held at 0.
- LOAD: COL_M consecutive cycles with load_a=load_w=1.
  - addr_a = A_BASE + k.
  - addr_w = W_BASE + t*W_TILE_STRIDE + k*W_STEP_STRIDE.
  - k increments each cycle. After k=COL_M-1, go to DRAIN with k=0.
- mac_en equals load_a delayed exactly RD_LAT cycles. acc_clr equals (load_a and k==0) delayed RD_LAT cycles. Implement both as shift registers, independent of the state.
- DRAIN: RD_LAT+PE_LAT cycles with no strobes. It covers the last mac and accumulator settle.
- STORE0: deload_out=1 for exactly one cycle, addr_res = C_BASE + t*ROW_A.
- STORE1: deload_out=0 and addr_res held. The RAM registers deload_out one cycle, so addr_res must be stable across both cycles. Then t increments.
- DUMP: test_en=1 for exactly NUM_TILES*ROW_A consecutive cycles. Then done=1 for one cycle, busy=0 in that same cycle, and the state returns to IDLE.
- A new start in the cycle done is high is ignored. A start is accepted from the next cycle on.
- load_a and load_w are never high in STORE/DUMP. deload_out never coincides with load_*.
- Cycles per tile = COL_M + RD_LAT + PE_LAT + 2.
- Total cycles start->done = NUM_TILES*(COL_M+RD_LAT+PE_LAT+2) + NUM_TILES*ROW_A + 1.

Test Plan:
- Small config: ROW_A=4, COL_M=4, NUM_TILES=2, defaults otherwise; start at cycle 0.
  - Required: load_a high cycles 1-4 with addr_a 0,1,2,3.
  - Required: addr_w 256,257,258,259, then tile 1 addr_w 272..275.
  - Required: deload_out at cycle 8 with addr_res=512, tile 1 with addr_res=516.
  - Required: test_en high for 8 cycles, then done exactly once.
- Same config, latency alignment: mac_en high exactly 2 cycles after each load_a. acc_clr high only alongside the first mac_en of each tile (2 pulses total).
- Reset mid-run: drop rst_n during tile 1 LOAD -> all outputs 0 asynchronously, no done. After release, a new start repeats the full sequence from t=0.
- start held high for the whole run -> exactly one run, and busy stays high throughout. A start pulse arriving during DUMP is ignored.
- Address wrap: ADDR_WIDTH=4, A_BASE=14, COL_M=4 -> addr_a sequence 14,15,0,1.
- End-to-end with the RAM and the vector unit (defaults, known A/W image): words 512..767 match the golden product, and test_data streams them in order.
